// File: rtl/decode_issue_ctrl_pkg.sv
// Shared decode constants: RV32 opcodes, immediate-format select encodings and decode FSM states.
// The immediate generator imports this package so both sides agree on the imm_sel encoding.
package decode_issue_ctrl_pkg;

    localparam logic [6:0] OpcLoad     = 7'b0000011;
    localparam logic [6:0] OpcMiscMem  = 7'b0001111;
    localparam logic [6:0] OpcAriItype = 7'b0010011;
    localparam logic [6:0] OpcAuipc    = 7'b0010111;
    localparam logic [6:0] OpcStore    = 7'b0100011;
    localparam logic [6:0] OpcRtype    = 7'b0110011;
    localparam logic [6:0] OpcLui      = 7'b0110111;
    localparam logic [6:0] OpcBranch   = 7'b1100011;
    localparam logic [6:0] OpcJalr     = 7'b1100111;
    localparam logic [6:0] OpcJal      = 7'b1101111;
    localparam logic [6:0] OpcCsr      = 7'b1110011;

    localparam logic [2:0] ImmSelNone   = 3'd0;
    localparam logic [2:0] ImmSelI      = 3'd1;
    localparam logic [2:0] ImmSelIShamt = 3'd2;
    localparam logic [2:0] ImmSelS      = 3'd3;
    localparam logic [2:0] ImmSelB      = 3'd4;
    localparam logic [2:0] ImmSelU      = 3'd5;
    localparam logic [2:0] ImmSelJ      = 3'd6;
    localparam logic [2:0] ImmSelCsr    = 3'd7;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StFull  = 2'd1,
        StStall = 2'd2
    } dec_state_e;

    function automatic logic opc_legal(input logic [6:0] opc);
        logic legal;
        case (opc)
            OpcLoad, OpcMiscMem, OpcAriItype, OpcAuipc, OpcStore, OpcRtype,
            OpcLui, OpcBranch, OpcJalr, OpcJal, OpcCsr: legal = 1'b1;
            default:                                    legal = 1'b0;
        endcase
        return legal;
    endfunction

    function automatic logic [2:0] imm_sel_of(input logic [6:0] opc, input logic [2:0] funct3);
        logic [2:0] sel;
        case (opc)
            OpcLoad, OpcJalr: sel = ImmSelI;
            // funct3 001/101 are the shift-immediate forms
            OpcAriItype:      sel = (funct3[1:0] == 2'b01) ? ImmSelIShamt : ImmSelI;
            OpcStore:         sel = ImmSelS;
            OpcBranch:        sel = ImmSelB;
            OpcLui, OpcAuipc: sel = ImmSelU;
            OpcJal:           sel = ImmSelJ;
            OpcCsr: begin
                if (funct3[2])              sel = ImmSelCsr;
                else if (funct3 == 3'b000)  sel = ImmSelNone;
                else                        sel = ImmSelI;
            end
            default:          sel = ImmSelNone;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/dec_hazard_unit.sv
// Combinational load-use hazard check of the decoded instruction against the load in EX.
module dec_hazard_unit
    import decode_issue_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic       i_funct3_msb,
    input  logic [4:0] i_rs1,
    input  logic [4:0] i_rs2,
    input  logic       i_ex_valid,
    input  logic       i_ex_is_load,
    input  logic [4:0] i_ex_rd,
    output logic       o_hazard
);

    logic w_uses_rs1;
    logic w_uses_rs2;
    logic w_rs1_hit;
    logic w_rs2_hit;

    always_comb begin
        w_uses_rs1 = (i_opcode != OpcLui) && (i_opcode != OpcAuipc) && (i_opcode != OpcJal) &&
                     ((i_opcode != OpcCsr) || !i_funct3_msb);
        w_uses_rs2 = (i_opcode == OpcRtype) || (i_opcode == OpcStore) || (i_opcode == OpcBranch);
        w_rs1_hit  = w_uses_rs1 && (i_rs1 == i_ex_rd);
        w_rs2_hit  = w_uses_rs2 && (i_rs2 == i_ex_rd);
        // x0 never carries a real dependency
        o_hazard   = i_ex_valid && i_ex_is_load && (i_ex_rd != 5'd0) && (w_rs1_hit || w_rs2_hit);
    end

endmodule

// File: rtl/decode_issue_ctrl.sv
// Decode-stage controller: IF/ID register, instruction classification, load-use stall and flush.
// Optional load-use stall counter enabled by defining DEC_PERF_CNT_EN.
module decode_issue_ctrl
    import decode_issue_ctrl_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_if_valid,
    output logic             o_if_ready,
    input  logic [31:0]      i_if_inst,
    input  logic [XLEN-1:0]  i_if_pc,
    output logic             o_id_valid,
    input  logic             i_id_ready,
    output logic [31:0]      o_id_inst,
    output logic [XLEN-1:0]  o_id_pc,
    output logic [2:0]       o_id_imm_sel,
    output logic [4:0]       o_id_rs1,
    output logic [4:0]       o_id_rs2,
    output logic [4:0]       o_id_rd,
    output logic             o_id_illegal,
    input  logic             i_ex_valid,
    input  logic             i_ex_is_load,
    input  logic [4:0]       i_ex_rd,
    input  logic             i_flush,
    output logic [CNT_W-1:0] o_stall_cnt
);

    dec_state_e      r_state;
    dec_state_e      w_state_next;
    logic [31:0]     r_inst;
    logic [XLEN-1:0] r_pc;
    logic            w_hazard;
    logic            w_capture;

    dec_hazard_unit u_hazard (
        .i_opcode     (r_inst[6:0]),
        .i_funct3_msb (r_inst[14]),
        .i_rs1        (r_inst[19:15]),
        .i_rs2        (r_inst[24:20]),
        .i_ex_valid   (i_ex_valid),
        .i_ex_is_load (i_ex_is_load),
        .i_ex_rd      (i_ex_rd),
        .o_hazard     (w_hazard)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StEmpty;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StEmpty: begin
                if (i_if_valid) w_state_next = StFull;
            end
            StFull: begin
                if (w_hazard)                       w_state_next = StStall;
                else if (i_id_ready && !i_if_valid) w_state_next = StEmpty;
            end
            StStall: begin
                if (!w_hazard) w_state_next = StFull;
            end
            default: w_state_next = StEmpty;
        endcase
        if (i_flush) w_state_next = StEmpty;
    end

    always_comb begin
        o_id_valid = 1'b0;
        o_if_ready = 1'b0;
        unique case (r_state)
            StEmpty: o_if_ready = 1'b1;
            StFull: begin
                o_id_valid = !w_hazard;
                o_if_ready = i_id_ready && !w_hazard;
            end
            default: ;
        endcase
        // Flush drops the held and the incoming instruction in the same cycle
        if (i_flush || i_rst) begin
            o_id_valid = 1'b0;
            o_if_ready = 1'b0;
        end
    end

    assign w_capture = o_if_ready && i_if_valid;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_inst <= '0;
            r_pc   <= '0;
        end else if (w_capture) begin
            r_inst <= i_if_inst;
            r_pc   <= i_if_pc;
        end
    end

    assign o_id_inst    = r_inst;
    assign o_id_pc      = r_pc;
    assign o_id_rs1     = r_inst[19:15];
    assign o_id_rs2     = r_inst[24:20];
    assign o_id_rd      = r_inst[11:7];
    assign o_id_imm_sel = imm_sel_of(r_inst[6:0], r_inst[14:12]);
    assign o_id_illegal = !opc_legal(r_inst[6:0]);

`ifdef DEC_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stall_cnt <= '0;
        end else if ((r_state == StStall) && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`else
    assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Self-checking bench for decode_issue_ctrl: directed scenarios plus a randomized run against a
// queue-based reference model of the decode slot.
module tb_decode_issue_ctrl;

`ifdef DEC_PERF_CNT_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [2:0]  id_imm_sel;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic        id_illegal;
    logic        ex_valid;
    logic        ex_is_load;
    logic [4:0]  ex_rd;
    logic        flush;
    logic [31:0] stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    decode_issue_ctrl dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_if_valid   (if_valid),
        .o_if_ready   (if_ready),
        .i_if_inst    (if_inst),
        .i_if_pc      (if_pc),
        .o_id_valid   (id_valid),
        .i_id_ready   (id_ready),
        .o_id_inst    (id_inst),
        .o_id_pc      (id_pc),
        .o_id_imm_sel (id_imm_sel),
        .o_id_rs1     (id_rs1),
        .o_id_rs2     (id_rs2),
        .o_id_rd      (id_rd),
        .o_id_illegal (id_illegal),
        .i_ex_valid   (ex_valid),
        .i_ex_is_load (ex_is_load),
        .i_ex_rd      (ex_rd),
        .i_flush      (flush),
        .o_stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // Reference classification from the ISA encoding rules
    function automatic logic [2:0] ref_imm_sel(input logic [31:0] w);
        logic [6:0] op;
        logic [2:0] f3;
        op = w[6:0];
        f3 = w[14:12];
        case (op)
            7'h03, 7'h67: return 3'd1;
            7'h13:        return (f3 == 3'b001 || f3 == 3'b101) ? 3'd2 : 3'd1;
            7'h23:        return 3'd3;
            7'h63:        return 3'd4;
            7'h37, 7'h17: return 3'd5;
            7'h6F:        return 3'd6;
            7'h73:        return f3[2] ? 3'd7 : ((f3 == 3'b000) ? 3'd0 : 3'd1);
            default:      return 3'd0;
        endcase
    endfunction

    function automatic logic ref_illegal(input logic [31:0] w);
        logic [6:0] op;
        op = w[6:0];
        return !(op inside {7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67,
                            7'h6F, 7'h73});
    endfunction

    function automatic logic ref_hazard(input logic [31:0] w, input logic exv, input logic exl,
                                        input logic [4:0] exrd);
        logic [6:0] op;
        logic       u1;
        logic       u2;
        op = w[6:0];
        u1 = !(op inside {7'h37, 7'h17, 7'h6F}) && (op != 7'h73 || !w[14]);
        u2 = op inside {7'h33, 7'h23, 7'h63};
        return exv && exl && (exrd != 5'd0) &&
               ((u1 && w[19:15] == exrd) || (u2 && w[24:20] == exrd));
    endfunction

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic rdy, input logic exv, input logic exl,
                         input logic [4:0] exrd, input logic fl);
        @(negedge clk);
        if_valid   = v;
        if_inst    = inst;
        if_pc      = pc;
        id_ready   = rdy;
        ex_valid   = exv;
        ex_is_load = exl;
        ex_rd      = exrd;
        flush      = fl;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 32'h00500093, 32'h10, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        n_checks++;
        if (if_ready !== 1'b0) begin
            n_errors++; $display("FAIL reset_if_ready: got %b want 0", if_ready);
        end
        n_checks++;
        if (id_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_id_valid: got %b want 0", id_valid);
        end
        n_checks++;
        if (id_inst !== 32'h0 || id_pc !== 32'h0) begin
            n_errors++; $display("FAIL reset_regs: got inst %h pc %h want 0 0", id_inst, id_pc);
        end
        n_checks++;
        if (stall_cnt !== 32'd0) begin
            n_errors++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
        end
        if_valid = 1'b0;
        rst = 1'b0;
        #1;
        n_checks++;
        if (if_ready !== 1'b1 || id_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_release: got rdy %b vld %b want 1 0", if_ready, id_valid);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 32'h00500093, 32'h100, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        n_checks++;
        if (if_ready !== 1'b1 || id_valid !== 1'b0) begin
            n_errors++; $display("FAIL b2b_c0: got rdy %b vld %b want 1 0", if_ready, id_valid);
        end
        drive(1'b1, 32'h00108113, 32'h104, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        n_checks++;
        if (id_valid !== 1'b1 || if_ready !== 1'b1 || id_inst !== 32'h00500093 ||
            id_pc !== 32'h100 || id_imm_sel !== 3'd1 || id_rd !== 5'd1) begin
            n_errors++;
            $display("FAIL b2b_first: got vld %b rdy %b inst %h pc %h sel %0d rd %0d want 1 1 00500093 100 1 1",
                     id_valid, if_ready, id_inst, id_pc, id_imm_sel, id_rd);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        n_checks++;
        if (id_valid !== 1'b1 || if_ready !== 1'b1 || id_inst !== 32'h00108113 ||
            id_pc !== 32'h104 || id_imm_sel !== 3'd1 || id_rs1 !== 5'd1 || id_rd !== 5'd2) begin
            n_errors++;
            $display("FAIL b2b_second: got vld %b rdy %b inst %h pc %h sel %0d rs1 %0d rd %0d want 1 1 00108113 104 1 1 2",
                     id_valid, if_ready, id_inst, id_pc, id_imm_sel, id_rs1, id_rd);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        n_checks++;
        if (id_valid !== 1'b0 || if_ready !== 1'b1) begin
            n_errors++; $display("FAIL b2b_drain: got vld %b rdy %b want 0 1", id_valid, if_ready);
        end
    endtask

    logic [31:0] fmt_inst [11] = '{32'h00309093, 32'h00112223, 32'h00208463, 32'h000000EF,
                                   32'h3000D073, 32'h0000007F, 32'h000080B7, 32'h002081B3,
                                   32'h00012083, 32'h4020D093, 32'h000080E7};
    logic [2:0]  fmt_sel  [11] = '{3'd2, 3'd3, 3'd4, 3'd6, 3'd7, 3'd0, 3'd5, 3'd0, 3'd1,
                                   3'd2, 3'd1};
    logic        fmt_ill  [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                   1'b0, 1'b0};

    task automatic test_formats();
        for (int i = 0; i <= 11; i++) begin
            drive(i < 11, (i < 11) ? fmt_inst[i] : 32'h0, 32'h1000 + 32'(i * 4), 1'b1,
                  1'b0, 1'b0, 5'd0, 1'b0);
            if (i > 0) begin
                n_checks++;
                if (id_valid !== 1'b1 || id_inst !== fmt_inst[i-1] ||
                    id_imm_sel !== fmt_sel[i-1] || id_illegal !== fmt_ill[i-1]) begin
                    n_errors++;
                    $display("FAIL format_%0d: got vld %b inst %h sel %0d ill %b want 1 %h %0d %b",
                             i - 1, id_valid, id_inst, id_imm_sel, id_illegal,
                             fmt_inst[i-1], fmt_sel[i-1], fmt_ill[i-1]);
                end
            end
        end
    endtask

    task automatic test_load_use();
        drive(1'b1, 32'h002081B3, 32'h200, 1'b1, 1'b1, 1'b1, 5'd1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 5'd1, 1'b0);
        n_checks++;
        if (id_valid !== 1'b0 || if_ready !== 1'b0) begin
            n_errors++; $display("FAIL loaduse_hazard: got vld %b rdy %b want 0 0", id_valid, if_ready);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        n_checks++;
        if (id_valid !== 1'b0 || if_ready !== 1'b0) begin
            n_errors++; $display("FAIL loaduse_stall: got vld %b rdy %b want 0 0", id_valid, if_ready);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        n_checks++;
        if (id_valid !== 1'b1 || id_inst !== 32'h002081B3 || id_pc !== 32'h200) begin
            n_errors++;
            $display("FAIL loaduse_issue: got vld %b inst %h pc %h want 1 002081b3 200",
                     id_valid, id_inst, id_pc);
        end
        n_checks++;
        if (stall_cnt !== (PerfEn ? 32'd1 : 32'd0)) begin
            n_errors++; $display("FAIL loaduse_cnt: got %0d want %0d", stall_cnt, PerfEn ? 1 : 0);
        end
    endtask

    task automatic test_no_false_stall();
        drive(1'b1, 32'h002081B3, 32'h300, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        drive(1'b1, 32'h000080B7, 32'h304, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0);
        n_checks++;
        if (id_valid !== 1'b1 || if_ready !== 1'b1 || id_inst !== 32'h002081B3) begin
            n_errors++;
            $display("FAIL nostall_rd0: got vld %b rdy %b inst %h want 1 1 002081b3",
                     id_valid, if_ready, id_inst);
        end
        drive(1'b1, 32'h002081B3, 32'h308, 1'b1, 1'b1, 1'b1, 5'd1, 1'b0);
        n_checks++;
        if (id_valid !== 1'b1 || id_inst !== 32'h000080B7 || id_imm_sel !== 3'd5) begin
            n_errors++;
            $display("FAIL nostall_lui: got vld %b inst %h sel %0d want 1 000080b7 5",
                     id_valid, id_inst, id_imm_sel);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 5'd1, 1'b0);
        n_checks++;
        if (id_valid !== 1'b1 || id_inst !== 32'h002081B3) begin
            n_errors++; $display("FAIL nostall_notload: got vld %b inst %h want 1 002081b3", id_valid, id_inst);
        end
    endtask

    task automatic test_backpressure();
        drive(1'b1, 32'h00112223, 32'h400, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h00500093, 32'h404, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
            n_checks++;
            if (id_valid !== 1'b1 || if_ready !== 1'b0 || id_inst !== 32'h00112223 ||
                id_pc !== 32'h400 || id_imm_sel !== 3'd3) begin
                n_errors++;
                $display("FAIL bp_hold_%0d: got vld %b rdy %b inst %h pc %h sel %0d want 1 0 00112223 400 3",
                         i, id_valid, if_ready, id_inst, id_pc, id_imm_sel);
            end
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        n_checks++;
        if (id_valid !== 1'b1 || id_inst !== 32'h00112223 || id_pc !== 32'h400) begin
            n_errors++; $display("FAIL bp_issue: got vld %b inst %h pc %h want 1 00112223 400", id_valid, id_inst, id_pc);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        n_checks++;
        if (id_valid !== 1'b0 || id_pc !== 32'h400) begin
            n_errors++; $display("FAIL bp_after: got vld %b pc %h want 0 400", id_valid, id_pc);
        end
    endtask

    task automatic test_flush_stall();
        drive(1'b1, 32'h002081B3, 32'h500, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 5'd2, 1'b0);
        drive(1'b1, 32'h00500093, 32'h504, 1'b1, 1'b1, 1'b1, 5'd2, 1'b1);
        n_checks++;
        if (id_valid !== 1'b0 || if_ready !== 1'b0) begin
            n_errors++; $display("FAIL flush_cycle: got vld %b rdy %b want 0 0", id_valid, if_ready);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        n_checks++;
        if (id_valid !== 1'b0 || if_ready !== 1'b1 || id_pc !== 32'h500) begin
            n_errors++;
            $display("FAIL flush_empty: got vld %b rdy %b pc %h want 0 1 500", id_valid, if_ready, id_pc);
        end
        n_checks++;
        if (stall_cnt !== (PerfEn ? 32'd2 : 32'd0)) begin
            n_errors++; $display("FAIL flush_cnt: got %0d want %0d", stall_cnt, PerfEn ? 2 : 0);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        n_checks++;
        if (id_valid !== 1'b0) begin
            n_errors++; $display("FAIL flush_noreissue: got vld %b want 0", id_valid);
        end
    endtask

    task automatic test_reset_mid_stall();
        drive(1'b1, 32'h00208463, 32'h600, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 5'd2, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 5'd2, 1'b0);
        rst = 1'b1;
        #1;
        n_checks++;
        if (id_valid !== 1'b0 || if_ready !== 1'b0 || id_inst !== 32'h0 || stall_cnt !== 32'd0) begin
            n_errors++;
            $display("FAIL rststall_async: got vld %b rdy %b inst %h cnt %0d want 0 0 0 0",
                     id_valid, if_ready, id_inst, stall_cnt);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        rst = 1'b0;
        #1;
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        n_checks++;
        if (id_valid !== 1'b0 || if_ready !== 1'b1) begin
            n_errors++; $display("FAIL rststall_empty: got vld %b rdy %b want 0 1", id_valid, if_ready);
        end
    endtask

    logic [31:0] rnd_tmpl [11] = '{32'h00309093, 32'h00112223, 32'h00208463, 32'h000000EF,
                                   32'h3000D073, 32'h0000007F, 32'h000080B7, 32'h002081B3,
                                   32'h00012083, 32'h4020D093, 32'h000080E7};

    task automatic test_random();
        logic [63:0] q[$];
        logic        blocked;
        int          stalls;
        logic [31:0] w;
        logic [31:0] pc;
        logic [31:0] h;
        logic        v, rdy, exv, exl, fl, held, haz, exp_v, exp_r, issued, accepted;
        logic [4:0]  exrd;

        rst = 1'b1;
        #1;
        @(negedge clk);
        rst = 1'b0;
        blocked = 1'b0;
        stalls  = 0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            w        = rnd_tmpl[$urandom_range(0, 10)];
            w[19:15] = 5'($urandom_range(0, 3));
            w[24:20] = 5'($urandom_range(0, 3));
            pc       = $urandom;
            v        = ($urandom_range(0, 9) < 7);
            rdy      = ($urandom_range(0, 9) < 7);
            exv      = ($urandom_range(0, 1) == 1);
            exl      = ($urandom_range(0, 1) == 1);
            exrd     = 5'($urandom_range(0, 3));
            fl       = ($urandom_range(0, 19) == 0);
            drive(v, w, pc, rdy, exv, exl, exrd, fl);

            held  = (q.size() != 0);
            h     = held ? q[0][31:0] : 32'h0;
            haz   = held && ref_hazard(h, exv, exl, exrd);
            exp_v = held && !fl && !haz && !blocked;
            exp_r = !fl && (!held || (exp_v && rdy));

            n_checks++;
            if (id_valid !== exp_v || if_ready !== exp_r) begin
                n_errors++;
                $display("FAIL rand_hs cyc %0d: got vld %b rdy %b want %b %b", cyc, id_valid,
                         if_ready, exp_v, exp_r);
            end
            if (held) begin
                n_checks++;
                if (id_inst !== h || id_pc !== q[0][63:32] || id_imm_sel !== ref_imm_sel(h) ||
                    id_illegal !== ref_illegal(h) || id_rs1 !== h[19:15] ||
                    id_rs2 !== h[24:20] || id_rd !== h[11:7]) begin
                    n_errors++;
                    $display("FAIL rand_slot cyc %0d: got inst %h pc %h sel %0d ill %b want %h %h %0d %b",
                             cyc, id_inst, id_pc, id_imm_sel, id_illegal, h, q[0][63:32],
                             ref_imm_sel(h), ref_illegal(h));
                end
            end
            n_checks++;
            if (stall_cnt !== (PerfEn ? 32'(stalls) : 32'd0)) begin
                n_errors++;
                $display("FAIL rand_cnt cyc %0d: got %0d want %0d", cyc, stall_cnt,
                         PerfEn ? stalls : 0);
            end

            if (held && blocked) stalls++;
            issued   = exp_v && rdy;
            accepted = exp_r && v;
            if (fl) begin
                q.delete();
                blocked = 1'b0;
            end else begin
                if (issued) void'(q.pop_front());
                if (accepted) begin
                    q.push_back({pc, w});
                    blocked = 1'b0;
                end else if (q.size() != 0) begin
                    blocked = haz;
                end else begin
                    blocked = 1'b0;
                end
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        if_valid   = 1'b0;
        if_inst    = 32'h0;
        if_pc      = 32'h0;
        id_ready   = 1'b0;
        ex_valid   = 1'b0;
        ex_is_load = 1'b0;
        ex_rd      = 5'd0;
        flush      = 1'b0;
        test_reset();
        test_back_to_back();
        test_formats();
        test_load_use();
        test_no_false_stall();
        test_backpressure();
        test_flush_stall();
        test_reset_mid_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
